// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial adder front-end.
// Holds the controller state encoding and the nibble extraction function.
package nibadd_pkg;

    localparam int NIB_W     = 4;
    localparam int NIB_MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [NIB_W-1:0] nib_sel(input logic [NIB_MAX_W-1:0] vec,
                                                 input int unsigned k);
        nib_sel = vec[k*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// Drives an external 4-bit adder slice one nibble per cycle (LSB first),
// chaining the carry through a register and returning the full-width sum.
module nibble_serial_add_ctrl
    import nibadd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;

    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W || WIDTH > NIB_MAX_W) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 in [4, 256]");
    end

    state_e               state_r;
    state_e               state_nx_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 carry_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     res_r;
    logic                 load_s;
    logic                 step_s;
    logic                 last_s;
    logic [NIB_MAX_W-1:0] a_ext_s;
    logic [NIB_MAX_W-1:0] b_ext_s;

    assign last_s = (cnt_r == CNT_W'(NNIB - 1));

    // Zero-extend operands to the helper's fixed vector width.
    always_comb begin
        a_ext_s = '0;
        b_ext_s = '0;
        a_ext_s[WIDTH-1:0] = a_r;
        b_ext_s[WIDTH-1:0] = b_r;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, handshake and slice-drive decode.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        slice_a    = 4'h0;
        slice_b    = 4'h0;
        slice_cin  = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_s     = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                step_s    = 1'b1;
                slice_a   = nib_sel(a_ext_s, 32'(cnt_r));
                slice_b   = nib_sel(b_ext_s, 32'(cnt_r));
                slice_cin = carry_r;
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                // Consuming and accepting on the same edge avoids an IDLE bubble.
                if (out_ready && in_valid) begin
                    load_s     = 1'b1;
                    state_nx_s = RUN;
                end else if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand capture, carry chaining and result nibble assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else if (load_s) begin
            a_r     <= in_a;
            b_r     <= in_b;
            carry_r <= in_cin;
            cnt_r   <= '0;
        end else if (step_s) begin
            res_r[int'(cnt_r)*NIB_W +: NIB_W] <= slice_sum;
            carry_r <= slice_cout;
            if (last_s) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            res_r   <= res_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    assign out_sum  = res_r;
    assign out_cout = carry_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with an exact 4-bit slice.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic [3:0]  slice_a;
    logic [3:0]  slice_b;
    logic        slice_cin;
    logic [3:0]  slice_sum;
    logic        slice_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic [4:0]  slice_res;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign slice_res  = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, slice_cin};
    assign slice_sum  = slice_res[3:0];
    assign slice_cout = slice_res[4];

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_sum(slice_sum), .slice_cout(slice_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output logic [15:0] s, output logic co, output int lat,
                         output logic [3:0] cins);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        cins = 4'h0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (lat < 4) cins[lat] = slice_cin;
            tick();
            lat++;
        end
        s = out_sum;
        co = out_cout;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_hs: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        n_checks++;
        if (out_sum !== 16'h0000 || out_cout !== 1'b0) begin
            n_fail++; $display("FAIL reset_out: got %h/%b want 0000/0", out_sum, out_cout);
        end
        n_checks++;
        if (slice_a !== 4'h0 || slice_b !== 4'h0 || slice_cin !== 1'b0) begin
            n_fail++; $display("FAIL reset_slice: got %h %h %b want 0 0 0", slice_a, slice_b, slice_cin);
        end
    endtask

    task automatic test_basic();
        logic [15:0] s; logic co; int lat; logic [3:0] cins;
        do_op(16'h1234, 16'h4321, 1'b0, s, co, lat, cins);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_checks++;
        if (s !== 16'h5555 || co !== 1'b0) begin
            n_fail++; $display("FAIL basic_sum: got %h/%b want 5555/0", s, co);
        end
        n_checks++;
        if (cins !== 4'b0000) begin n_fail++; $display("FAIL basic_cins: got %b want 0000", cins); end
    endtask

    task automatic test_ripple();
        logic [15:0] s; logic co; int lat; logic [3:0] cins;
        do_op(16'hFFFF, 16'h0001, 1'b0, s, co, lat, cins);
        n_checks++;
        if (s !== 16'h0000 || co !== 1'b1) begin
            n_fail++; $display("FAIL ripple_sum: got %h/%b want 0000/1", s, co);
        end
        n_checks++;
        if (cins !== 4'b1110) begin n_fail++; $display("FAIL ripple_cins: got %b want 1110", cins); end
    endtask

    task automatic test_carry_in();
        logic [15:0] s; logic co; int lat; logic [3:0] cins;
        do_op(16'hFFFF, 16'hFFFF, 1'b1, s, co, lat, cins);
        n_checks++;
        if (s !== 16'hFFFF || co !== 1'b1) begin
            n_fail++; $display("FAIL max_sum: got %h/%b want FFFF/1", s, co);
        end
        n_checks++;
        if (cins !== 4'b1111) begin n_fail++; $display("FAIL max_cins: got %b want 1111", cins); end
        do_op(16'h0000, 16'h0000, 1'b1, s, co, lat, cins);
        n_checks++;
        if (s !== 16'h0001 || co !== 1'b0) begin
            n_fail++; $display("FAIL cin_only_sum: got %h/%b want 0001/0", s, co);
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_consume: got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int wait_cyc;
        in_a = 16'hA5A5; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_cyc = 0;
        while (out_valid !== 1'b1 && wait_cyc < 20) begin tick(); wait_cyc++; end
        n_checks++;
        if (wait_cyc !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d want 4", wait_cyc); end
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            in_a = 16'hDEAD;
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== 16'hB6B6 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vld=%b sum=%h co=%b rdy=%b want 1 B6B6 0 0",
                         i, out_valid, out_sum, out_cout, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        in_a = 16'h00FF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_a = 16'h8000; in_b = 16'h8000;
        repeat (4) tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'h0100 || out_cout !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got vld=%b sum=%h co=%b rdy=%b want 1 0100 0 1",
                     out_valid, out_sum, out_cout, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || slice_a !== 4'h0 || slice_b !== 4'h0) begin
            n_fail++;
            $display("FAIL b2b_restart: got vld=%b rdy=%b sa=%h sb=%h want 0 0 0 0",
                     out_valid, in_ready, slice_a, slice_b);
        end
        repeat (4) tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_cout !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: got vld=%b sum=%h co=%b want 1 0000 1",
                               out_valid, out_sum, out_cout);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s; logic co; int lat; logic [3:0] cins;
        in_a = 16'h1234; in_b = 16'h5678; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (slice_a !== 4'h2 || slice_b !== 4'h6 || slice_cin !== 1'b0) begin
            n_fail++; $display("FAIL mid_slice: got %h %h %b want 2 6 0", slice_a, slice_b, slice_cin);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || slice_a !== 4'h0 || slice_b !== 4'h0 ||
            slice_cin !== 1'b0 || out_sum !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset: got vld=%b rdy=%b sa=%h sb=%h sc=%b sum=%h want 0 1 0 0 0 0000",
                     out_valid, in_ready, slice_a, slice_b, slice_cin, out_sum);
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        do_op(16'h0F0F, 16'h0101, 1'b0, s, co, lat, cins);
        n_checks++;
        if (lat !== 4 || s !== 16'h1010 || co !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_op: got lat=%0d %h/%b want 4 1010/0", lat, s, co);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_cin = 1'b0; out_ready = 1'b0;
        #2;
        test_reset();
        #10 rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_ripple();
        test_carry_in();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequential front-end for the team's 4-bit ripple-carry slice (a[3:0], b[3:0], cin in; sum[3:0], cout out).
- Accepts WIDTH-bit operand pairs over a valid/ready handshake and presents them to the external slice one nibble per cycle, LSB nibble first.
- Registers the slice carry between nibbles and assembles the WIDTH-bit sum plus final carry-out behind a second valid/ready handshake.
- Result: a wide adder built from one small slice, for area-constrained datapaths.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NNIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- slice_a  output  4  current A nibble to slice.
- slice_b  output  4  current B nibble to slice.
- slice_cin  output  1  carry to slice.
- slice_sum  input  4  slice sum, combinational response to slice_* this cycle.
- slice_cout  input  1  slice carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  assembled sum.
- out_cout  output  1  final carry-out.

Behaviour:
- Reset (asynchronous, immediate, any state including mid-RUN): state=IDLE, nibble counter=0, carry reg=0, operand regs=0, result regs=0. Outputs under reset: in_ready=1, out_valid=0, out_sum=0, out_cout=0, slice_*=0. An operation in flight is discarded; no partial result is ever emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a, in_b; carry reg<=in_cin; counter<=0; go RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Slice inputs: slice_a=a_reg[4k+3:4k], slice_b=b_reg[4k+3:4k], slice_cin=carry reg, where k=counter.
  - Each edge: result nibble k<=slice_sum; carry reg<=slice_cout; counter<=k+1.
  - When k==NNIB-1: go DONE instead of incrementing. The counter never wraps past NNIB-1.
- DONE:
  - out_valid=1; out_sum=result regs; out_cout=carry reg.
  - Outputs stay stable while out_ready=0, for any number of cycles.
  - On out_ready: the result is consumed.
  - in_ready=out_ready in DONE. If in_valid is also high on that edge, latch the new operands and go directly to RUN (back-to-back, no IDLE bubble). Otherwise go IDLE.
- slice_* outputs are 0 outside RUN. slice_sum and slice_cout are ignored outside RUN.
- Latency: out_valid rises NNIB cycles after the accepting edge (16-bit: 4 cycles).
- Throughput: one result per NNIB+1 cycles with back-to-back, i.e. with the consumer always ready and the producer always valid.
- Arithmetic: {out_cout,out_sum} == in_a+in_b+in_cin (WIDTH+1 bits), provided the slice is a correct 4-bit adder.
- Result regs are not cleared between operations. Every nibble is overwritten each operation before out_valid.
- Counter width: max(1, clog2(NNIB)).

Decomposition:
- Shared package nibadd_pkg: state enum (IDLE, RUN, DONE); constant NIB_W=4; function nib_sel(vector, k) returning nibble k.
- No sub-module required. The 4-bit slice stays external and is instantiated by the parent so the same slice can be swapped for approximate variants.
- Bench instantiates the exact 4-bit slice as the golden connection.

Test Plan (WIDTH=16, exact slice attached):
- Basic: a=0x1234, b=0x4321, cin=0, accept -> out_valid 4 cycles later. out_sum=0x5555, cout=0. slice_cin=0 on all 4 RUN cycles.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 -> out_sum=0x0000, cout=1. slice_cin sequence 0,1,1,1.
- Carry-in and max: a=0xFFFF, b=0xFFFF, cin=1 -> out_sum=0xFFFF, cout=1. Also a=0, b=0, cin=1 -> out_sum=0x0001, cout=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid, out_sum, out_cout stable. in_ready=0 throughout. in_valid pulses ignored.
- Back-to-back: in_valid held with ops (0x00FF+0x0001), then (0x8000+0x8000). out_ready=1 -> results 0x0100/cout0, then 0x0000/cout1. Second accept occurs on the same edge the first result is consumed.
- Reset mid-RUN: assert rst_n=0 at counter=2 -> asynchronously out_valid=0, in_ready=1, slice_*=0. After release, a fresh op 0x0F0F+0x0101 -> 0x1010, cout=0, with no stale nibbles.
